// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_if
// Description : Bundle of the host request port, the CPU request port, the
//               SRAM strobe/data bus and the arbiter status signals shared
//               between sram_port_arbiter and its environment.
//               The slave modport is the arbiter's view. The master modport is
//               the environment's view: the requesters and the SRAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    // load-mode mask for CPU requests
    logic                  hold_cpu;

    // host (serial control port) request channel
    logic                  c_req;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_ack;
    logic [DATA_WIDTH-1:0] c_rdata;

    // CPU request channel
    logic                  p_req;
    logic                  p_we;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_wdata;
    logic                  p_ack;
    logic [DATA_WIDTH-1:0] p_rdata;

    // SRAM macro bus, strobes active low
    logic                  sram_cen;
    logic                  sram_wen;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    // status
    logic                  busy;
    logic                  owner;

    modport slave (
        input  hold_cpu,
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  p_req, p_we, p_addr, p_wdata,
        output p_ack, p_rdata,
        output sram_cen, sram_wen, sram_a, sram_d,
        input  sram_q,
        output busy, owner
    );

    modport master (
        output hold_cpu,
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output p_req, p_we, p_addr, p_wdata,
        input  p_ack, p_rdata,
        input  sram_cen, sram_wen, sram_a, sram_d,
        output sram_q,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port SRAM between the host loader port and
//               the CPU. Every access runs through IDLE -> ACCESS -> RESP.
//               The SRAM strobes are asserted for exactly one cycle. Read data
//               is captured into the winner's read data register, and the
//               winner receives a one-cycle acknowledge.
//               hold_cpu masks new CPU grants. It does not affect an access
//               that is already in flight.
// Config      : SRAM_ARB_RR_EN defined   -> round-robin on ties
//                                           (the requester that is not the
//                                           last owner wins)
//               SRAM_ARB_RR_EN undefined -> host wins every tie
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs, each with its next-value wire
    // ------------------------------------------------------------------
    state_t                r_state,     w_state_nxt;
    logic                  r_sram_cen,  w_sram_cen_nxt;
    logic                  r_sram_wen,  w_sram_wen_nxt;
    logic [ADDR_WIDTH-1:0] r_sram_a,    w_sram_a_nxt;
    logic [DATA_WIDTH-1:0] r_sram_d,    w_sram_d_nxt;
    logic                  r_c_ack,     w_c_ack_nxt;
    logic                  r_p_ack,     w_p_ack_nxt;
    logic [DATA_WIDTH-1:0] r_c_rdata,   w_c_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_p_rdata,   w_p_rdata_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_owner,     w_owner_nxt;

    // ------------------------------------------------------------------
    // Arbitration terms
    // ------------------------------------------------------------------
    logic w_c_elig;
    logic w_p_elig;
    logic w_grant_cpu;
    logic w_any_elig;

    assign w_c_elig   = bus.c_req;
    assign w_p_elig   = bus.p_req & ~bus.hold_cpu;
    assign w_any_elig = w_c_elig | w_p_elig;

`ifdef SRAM_ARB_RR_EN
    // On a tie the CPU wins only if the host held the last grant.
    // Because owner resets to host, the first tie after reset goes to the CPU.
    assign w_grant_cpu = w_p_elig & (~w_c_elig | ~r_owner);
`else
    // The host wins every tie. The CPU is granted only while the host is idle.
    assign w_grant_cpu = w_p_elig & ~w_c_elig;
`endif

    // Next-state and next-output decode. Every register holds its value
    // unless a state explicitly changes it. The acknowledges default low.
    always_comb begin
        w_state_nxt    = r_state;
        w_sram_cen_nxt = r_sram_cen;
        w_sram_wen_nxt = r_sram_wen;
        w_sram_a_nxt   = r_sram_a;
        w_sram_d_nxt   = r_sram_d;
        w_c_ack_nxt    = 1'b0;
        w_p_ack_nxt    = 1'b0;
        w_c_rdata_nxt  = r_c_rdata;
        w_p_rdata_nxt  = r_p_rdata;
        w_busy_nxt     = r_busy;
        w_owner_nxt    = r_owner;

        case (r_state)
            ST_IDLE: begin
                if (w_any_elig) begin
                    // Latch the winner's request once. It is not sampled
                    // again until the next IDLE cycle.
                    w_state_nxt    = ST_ACCESS;
                    w_sram_cen_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_owner_nxt    = w_grant_cpu;
                    if (w_grant_cpu) begin
                        w_sram_wen_nxt = ~bus.p_we;
                        w_sram_a_nxt   = bus.p_addr;
                        w_sram_d_nxt   = bus.p_wdata;
                    end else begin
                        w_sram_wen_nxt = ~bus.c_we;
                        w_sram_a_nxt   = bus.c_addr;
                        w_sram_d_nxt   = bus.c_wdata;
                    end
                end
            end

            ST_ACCESS: begin
                // The SRAM samples the strobes at the end of this cycle.
                // Release the chip enable so that it is low for one cycle only.
                w_sram_cen_nxt = 1'b1;
                w_state_nxt    = ST_RESP;
            end

            ST_RESP: begin
                // sram_q is valid during this cycle. The write enable is still
                // latched, so a high value here marks the access as a read.
                if (r_owner) begin
                    w_p_ack_nxt = 1'b1;
                    if (r_sram_wen) begin
                        w_p_rdata_nxt = bus.sram_q;
                    end
                end else begin
                    w_c_ack_nxt = 1'b1;
                    if (r_sram_wen) begin
                        w_c_rdata_nxt = bus.sram_q;
                    end
                end
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_sram_cen_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any access in flight and
    // does not acknowledge it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sram_cen <= 1'b1;
            r_sram_wen <= 1'b1;
            r_sram_a   <= '0;
            r_sram_d   <= '0;
            r_c_ack    <= 1'b0;
            r_p_ack    <= 1'b0;
            r_c_rdata  <= '0;
            r_p_rdata  <= '0;
            r_busy     <= 1'b0;
            r_owner    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sram_cen <= w_sram_cen_nxt;
            r_sram_wen <= w_sram_wen_nxt;
            r_sram_a   <= w_sram_a_nxt;
            r_sram_d   <= w_sram_d_nxt;
            r_c_ack    <= w_c_ack_nxt;
            r_p_ack    <= w_p_ack_nxt;
            r_c_rdata  <= w_c_rdata_nxt;
            r_p_rdata  <= w_p_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every output comes straight from a register
    // ------------------------------------------------------------------
    assign bus.sram_cen = r_sram_cen;
    assign bus.sram_wen = r_sram_wen;
    assign bus.sram_a   = r_sram_a;
    assign bus.sram_d   = r_sram_d;
    assign bus.c_ack    = r_c_ack;
    assign bus.p_ack    = r_p_ack;
    assign bus.c_rdata  = r_c_rdata;
    assign bus.p_rdata  = r_p_rdata;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Bench for sram_port_arbiter. It contains a behavioural SRAM
//               and a reference memory image. Expected read data, acknowledge
//               latency and grant order follow the port rules.
//               The round-robin expectations apply when SRAM_ARB_RR_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    sram_port_arbiter_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: the strobes are sampled at the rising edge, and read
    // data appears one cycle later.
    logic [7:0] mem [0:511];
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_wen) mem[bus.sram_a] = bus.sram_d;
            else               bus.sram_q <= mem[bus.sram_a];
        end
    end

    // Reference memory image and the expected read data register per port
    logic [7:0] ref_mem [0:511];
    logic [7:0] exp_rdata [2];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge. The two acknowledges must never be
    // high in the same cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("dual_ack", 32'(bus.c_ack & bus.p_ack), 32'd0);
    endtask

    task automatic drive(input bit sel, input bit req, input bit we,
                         input logic [8:0] a, input logic [7:0] d);
        if (!sel) begin
            bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
        end else begin
            bus.p_req = req; bus.p_we = we; bus.p_addr = a; bus.p_wdata = d;
        end
    endtask

    task automatic wait_ack(input bit sel, input int max, output int lat,
                            output int lows, output bit found);
        lat = 0; lows = 0; found = 0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            lat++;
            if (!bus.sram_cen) lows++;
            if (sel ? bus.p_ack : bus.c_ack) found = 1;
        end
    endtask

    // One uncontested access with full checking. The task is entered and
    // left on a falling edge.
    task automatic single(input bit sel, input bit we, input logic [8:0] a,
                          input logic [7:0] d);
        int lat, lows;
        bit found;
        drive(sel, 1'b1, we, a, d);
        tick();
        chk("access_cen", 32'(bus.sram_cen), 32'd0);
        chk("access_wen", 32'(bus.sram_wen), 32'(!we));
        chk("access_addr", 32'(bus.sram_a), 32'(a));
        chk("access_busy", 32'(bus.busy), 32'd1);
        chk("access_owner", 32'(bus.owner), 32'(sel));
        if (we) chk("access_wdata", 32'(bus.sram_d), 32'(d));
        wait_ack(sel, 10, lat, lows, found);
        chk("ack_seen", 32'(found), 32'd1);
        chk("ack_latency", 32'(lat + 1), 32'd3);
        chk("cen_single_cycle", 32'(lows), 32'd0);
        chk("ack_busy_low", 32'(bus.busy), 32'd0);
        if (we) ref_mem[a] = d;
        else    exp_rdata[sel] = ref_mem[a];
        chk(sel ? "p_rdata" : "c_rdata", 32'(sel ? bus.p_rdata : bus.c_rdata), 32'(exp_rdata[sel]));
        chk(sel ? "c_rdata_kept" : "p_rdata_kept", 32'(sel ? bus.c_rdata : bus.p_rdata), 32'(exp_rdata[!sel]));
        drive(sel, 1'b0, we, a, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 9'd0, 8'd0);
        drive(1, 0, 0, 9'd0, 8'd0);
        bus.hold_cpu = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        tick();
    endtask

    // Directed sequence
    initial begin
        int lat, lows, start, k, ic, ip, nc, np;
        bit found, last, pick;
        bit exp_order [8];
        logic [7:0] dc [4];

        bus.hold_cpu = 1'b0;
        drive(0, 0, 0, 9'd0, 8'd0);
        drive(1, 0, 0, 9'd0, 8'd0);
        do_reset();

        // Reset state
        chk("rst_cen",     32'(bus.sram_cen), 32'd1);
        chk("rst_wen",     32'(bus.sram_wen), 32'd1);
        chk("rst_addr",    32'(bus.sram_a),   32'd0);
        chk("rst_d",       32'(bus.sram_d),   32'd0);
        chk("rst_c_ack",   32'(bus.c_ack),    32'd0);
        chk("rst_p_ack",   32'(bus.p_ack),    32'd0);
        chk("rst_c_rdata", 32'(bus.c_rdata),  32'd0);
        chk("rst_p_rdata", 32'(bus.p_rdata),  32'd0);
        chk("rst_busy",    32'(bus.busy),     32'd0);
        chk("rst_owner",   32'(bus.owner),    32'd0);

        // Host write 0xA5 to 0x020, then read it back
        single(0, 1, 9'h020, 8'hA5);
        single(0, 0, 9'h020, 8'h00);
        chk("host_readback", 32'(bus.c_rdata), 32'hA5);

        // Prefill a 16-byte window with random data from the host
        for (int i = 0; i < 16; i++) single(0, 1, 9'(i), 8'($urandom));
        single(0, 1, 9'h021, 8'($urandom));

        // CPU requests are masked while hold_cpu is high
        bus.hold_cpu = 1'b1;
        drive(1, 1, 0, 9'h021, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_no_ack", 32'(bus.p_ack),    32'd0);
            chk("hold_no_cen", 32'(bus.sram_cen), 32'd1);
        end
        bus.hold_cpu = 1'b0;
        wait_ack(1, 10, lat, lows, found);
        chk("hold_release_ack", 32'(found), 32'd1);
        chk("hold_release_lat", 32'(lat), 32'd3);
        chk("hold_release_cen", 32'(lows), 32'd1);
        exp_rdata[1] = ref_mem[9'h021];
        chk("hold_release_data", 32'(bus.p_rdata), 32'(exp_rdata[1]));
        drive(1, 0, 0, 9'h021, 8'h00);

        // CPU read after a host write; a later CPU write keeps p_rdata
        single(0, 1, 9'h004, 8'h0A);
        single(1, 0, 9'h004, 8'h00);
        chk("cpu_read_0a", 32'(bus.p_rdata), 32'h0A);
        single(1, 1, 9'h004, 8'h55);
        chk("cpu_write_keeps", 32'(bus.p_rdata), 32'h0A);

        // hold_cpu rises during the ACCESS cycle of a CPU read
        drive(1, 1, 0, 9'd5, 8'h00);
        tick();
        chk("hold_access_cen", 32'(bus.sram_cen), 32'd0);
        bus.hold_cpu = 1'b1;
        wait_ack(1, 10, lat, lows, found);
        chk("hold_access_ack", 32'(found), 32'd1);
        chk("hold_access_lat", 32'(lat + 1), 32'd3);
        exp_rdata[1] = ref_mem[5];
        chk("hold_access_data", 32'(bus.p_rdata), 32'(exp_rdata[1]));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("hold_pending_ack", 32'(bus.p_ack),    32'd0);
            chk("hold_pending_cen", 32'(bus.sram_cen), 32'd1);
        end
        bus.hold_cpu = 1'b0;
        wait_ack(1, 10, lat, lows, found);
        chk("hold_pending_served", 32'(found & (lat == 3)), 32'd1);
        drive(1, 0, 0, 9'd5, 8'h00);

        // Reset asserted during the ACCESS cycle of a host write
        drive(0, 1, 1, 9'h1F0, 8'h77);
        tick();
        chk("rst_mid_cen_low", 32'(bus.sram_cen), 32'd0);
        rst = 1'b1;
        drive(0, 0, 0, 9'h000, 8'h00);
        tick();
        chk("rst_mid_cen",   32'(bus.sram_cen), 32'd1);
        chk("rst_mid_busy",  32'(bus.busy),     32'd0);
        chk("rst_mid_c_ack", 32'(bus.c_ack),    32'd0);
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        tick();
        chk("rst_mid_no_late_ack", 32'(bus.c_ack), 32'd0);
        chk("rst_mid_c_rdata",     32'(bus.c_rdata), 32'd0);
        single(0, 1, 9'd7, 8'h3C);
        single(0, 0, 9'd7, 8'h00);

        // Contest: both ports request four back-to-back accesses
        do_reset();
        chk("contest_owner_rst", 32'(bus.owner), 32'd0);
        nc = 4; np = 4; last = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
            if (nc > 0 && np > 0) pick = !last;
            else                  pick = (np > 0);
`else
            pick = (nc == 0);
`endif
            exp_order[i] = pick;
            last = pick;
            if (pick) np--; else nc--;
        end
        for (int i = 0; i < 4; i++) dc[i] = 8'($urandom);
        drive(0, 1, 1, 9'd0, dc[0]);
        drive(1, 1, 0, 9'd8, 8'h00);
        start = cyc; k = 0; ic = 0; ip = 0;
        for (int t = 0; t < 40 && k < 8; t++) begin
            tick();
            if (bus.c_ack) begin
                chk("contest_order", 32'd0, 32'(exp_order[k]));
                chk("contest_spacing", 32'(cyc - start), 32'(3 * (k + 1)));
                ref_mem[ic] = dc[ic];
                ic++; k++;
                if (ic < 4) drive(0, 1, 1, 9'(ic), dc[ic]);
                else        drive(0, 0, 0, 9'd0, 8'h00);
            end
            if (bus.p_ack) begin
                chk("contest_order", 32'd1, 32'(exp_order[k]));
                chk("contest_spacing", 32'(cyc - start), 32'(3 * (k + 1)));
                exp_rdata[1] = ref_mem[8 + ip];
                chk("contest_p_rdata", 32'(bus.p_rdata), 32'(exp_rdata[1]));
                ip++; k++;
                if (ip < 4) drive(1, 1, 0, 9'(8 + ip), 8'h00);
                else        drive(1, 0, 0, 9'd0, 8'h00);
            end
        end
        chk("contest_all_acked", 32'(k), 32'd8);
        for (int i = 0; i < 4; i++) begin
            single(0, 0, 9'(i), 8'h00);
        end

        // Random uncontested traffic checked against the reference image
        for (int i = 0; i < 40; i++) begin
            single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   9'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: stops the run if the directed sequence stalls
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
